digit_serial_alu: RTL and testbench
===================================

Name: digit_serial_alu

Overview:
- Parametrised, multi-cycle successor to the team's 32-bit combinational ripple adder and bitwise AND/OR/negate blocks.
- Performs ADD, SUB, AND, OR and NEG (two's-complement negate) on WIDTH-bit operands, DIGIT bits per clock, LSB digit first, with the carry held in a register between digits.
- Uses a valid/ready handshake on both input and output, so it sits between a register-file read stage and a writeback stage.
- Trades latency for a short carry chain: only DIGIT bits of ripple per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- NDIG, WIDTH/DIGIT, derived localparam giving the number of compute cycles.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NEG, 5-7 reserved.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored for NEG.
- cin  in  1  carry-in; used by ADD only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- cout  out  1  carry out of the MSB; for SUB, 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - in_ready=1 from the following cycle; out_valid=0.
  - result, cout, overflow and zero are cleared to 0.
  - Internal carry and operand registers are cleared.
  - A reset during RUN or DONE aborts the operation; no result is ever presented for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op, a, b and cin, set digit index to 0, go to RUN.
  - RUN: in_ready=0. Process one digit per cycle. After the digit at index NDIG-1, go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, go to IDLE.
- Inputs are ignored outside IDLE; operands are registered at accept, so later input changes have no effect.
- Latency:
  - Accept edge is T.
  - Digit i is written at edge T+1+i.
  - out_valid rises after edge T+NDIG.
  - Throughput is one operation per NDIG+2 cycles at most.
  - A new request is not accepted in the same cycle as the output handshake.
- Per-digit operation:
  - ADD: A + B, initial carry = cin.
  - SUB: A + ~B, initial carry = 1.
  - NEG: ~A + 0, initial carry = 1.
  - AND / OR: bitwise on the digit; carry is unused.
  - Each digit's carry-out is registered and becomes the carry-in of the next digit.
- Flags:
  - cout is the final digit's carry-out for ADD, SUB and NEG; 0 for AND and OR.
  - overflow = carry into the MSB XOR carry out of the MSB, for ADD, SUB and NEG; 0 otherwise.
  - zero is computed over the full assembled result.
- Reserved ops 5-7: result=0, cout=0, overflow=0, zero=1; latency is identical to a legal op.
- Output hold: while out_valid=1 and out_ready=0, result and all flags stay stable. They also stay stable after the handshake until the next operation writes them.
- DIGIT=WIDTH gives NDIG=1 (one compute cycle). DIGIT=1 gives fully bit-serial operation.
- Wrap-around: the digit index counts 0..NDIG-1 and is reset on every accept.

Decomposition:
- Shared package alu_pkg holds:
  - Op-code localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG.
  - The FSM state encoding IDLE, RUN, DONE.
- Sub-module digit_adder, parametrised by DIGIT:
  - A DIGIT-bit gate-level ripple of full-adder cells.
  - Outputs sum, carry out of the top bit, and carry into the top bit; the last of these is used for overflow on the final digit.
- The top level holds the FSM, operand/result shift registers, carry register and flag logic.

Test Plan (WIDTH=32, DIGIT=8):
1. ADD a=9, b=10, cin=0 -> result=19, cout=0, overflow=0, zero=0; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
2. SUB a=43, b=20 -> result=23, cout=1. Then SUB a=20, b=43 -> result=0xFFFFFFE9, cout=0, overflow=0.
3. Carry across every digit boundary:
   - ADD 0xFFFFFFFF + 1, cin=0 -> result=0, cout=1, zero=1, overflow=0.
   - ADD 0x7FFFFFFF + 1 -> result=0x80000000, overflow=1, cout=0.
4. NEG and bitwise:
   - NEG a=1 -> 0xFFFFFFFF.
   - NEG a=0x80000000 -> 0x80000000, overflow=1.
   - NEG a=0 -> result=0, zero=1, cout=1.
   - AND 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000.
   - OR of the same operands -> 0xFFF0FFF0.
   - op=6 -> result=0, zero=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggle in_valid and change a/b -> result and flags stay stable, in_ready=0, no new op is accepted. Release out_ready -> in_ready=1 on the next cycle.
6. Reset and parameter sweep:
   - Assert rst_n=0 for one edge in the 2nd RUN cycle of ADD 0xFFFFFFFF+1 -> next cycle in_ready=1, out_valid=0, all outputs 0.
   - A following ADD 3+4 -> 7, with no stale carry.
   - Repeat scenarios 1-4 with DIGIT=1 (32-cycle latency) and DIGIT=32 (1-cycle latency).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code and FSM-state constants for the digit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Ops that go through the adder and therefore produce cout/overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple of full-adder cells; also exposes the carry into the top
// bit so the caller can form signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar k = 0; k < DIGIT; k++) begin : g_fa
    assign o_sum[k]   = i_x[k] ^ i_y[k] ^ w_c[k];
    assign w_c[k + 1] = (i_x[k] & i_y[k]) | (w_c[k] & (i_x[k] ^ i_y[k]));
  end

  assign o_co    = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_alu.sv
// Multi-cycle ADD/SUB/AND/OR/NEG, DIGIT bits per clock, LSB digit first.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
module digit_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_cout, r_ovf, r_zero;

  logic [DIGIT-1:0] w_x, w_y, w_sum, w_dig;
  logic             w_co, w_c_msb, w_arith, w_init_c;
  logic [WIDTH-1:0] w_a_next, w_b_next, w_res_next;

  digit_adder #(.DIGIT(DIGIT)) u_add (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_ci   (r_carry),
    .o_sum  (w_sum),
    .o_co   (w_co),
    .o_c_msb(w_c_msb)
  );

  // Operands shift right so the current digit is always in the low bits;
  // the result shifts in from the top and is fully aligned after NDIG digits.
  if (DIGIT == WIDTH) begin : g_single
    assign w_a_next   = '0;
    assign w_b_next   = '0;
    assign w_res_next = w_dig;
  end else begin : g_multi
    assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_res_next = {w_dig, r_res[WIDTH-1:DIGIT]};
  end

  assign w_arith  = is_arith(r_op);
  assign w_init_c = (op == OP_ADD) ? cin : ((op == OP_SUB) || (op == OP_NEG));

  always_comb begin
    w_x   = r_a[DIGIT-1:0];
    w_y   = r_b[DIGIT-1:0];
    w_dig = '0;
    case (r_op)
      OP_SUB: w_y = ~r_b[DIGIT-1:0];
      OP_NEG: begin
        w_x = ~r_a[DIGIT-1:0];
        w_y = '0;
      end
      default: ;
    endcase
    case (r_op)
      OP_ADD, OP_SUB, OP_NEG: w_dig = w_sum;
      OP_AND:                 w_dig = r_a[DIGIT-1:0] & r_b[DIGIT-1:0];
      OP_OR:                  w_dig = r_a[DIGIT-1:0] | r_b[DIGIT-1:0];
      default:                w_dig = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_init_c;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_res   <= w_res_next;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_state <= DONE;
            r_cout  <= w_arith & w_co;
            r_ovf   <= w_arith & (w_co ^ w_c_msb);
            r_zero  <= (w_res_next == '0);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_res;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu: three instances (DIGIT=8, 1, 32) run directed and
// random operations against an arithmetic reference model and a result queue.
module tb_digit_serial_alu;

  localparam int WIDTH = 32;
  localparam int EW    = WIDTH + 3;
  localparam int MSB   = WIDTH - 1;
  localparam int NV    = 11;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic clk;
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Expected bundle {zero, overflow, cout, result} from plain arithmetic.
  function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y, input logic ci);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c, v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        v = (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: begin
        r = -x;
        c = (x == '0);
        v = (x == MIN_NEG);
      end
      default: ;
    endcase
    return {(r == '0), v, c, r};
  endfunction

  function automatic logic [EW-1:0] e(input logic z, input logic v, input logic c,
                                      input logic [WIDTH-1:0] r);
    return {z, v, c, r};
  endfunction

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [EW-1:0]    exp_v;
  } vec_t;

  function automatic vec_t vec(input int i);
    vec_t v;
    case (i)
      0:  v = '{3'd0, 32'd9,        32'd10,       1'b0, e(0, 0, 0, 32'd19)};
      1:  v = '{3'd1, 32'd43,       32'd20,       1'b1, e(0, 0, 1, 32'd23)};
      2:  v = '{3'd1, 32'd20,       32'd43,       1'b0, e(0, 0, 0, 32'hFFFF_FFE9)};
      3:  v = '{3'd0, 32'hFFFF_FFFF, 32'd1,       1'b0, e(1, 0, 1, 32'h0)};
      4:  v = '{3'd0, 32'h7FFF_FFFF, 32'd1,       1'b0, e(0, 1, 0, 32'h8000_0000)};
      5:  v = '{3'd4, 32'd1,        32'h1234_5678, 1'b0, e(0, 0, 0, 32'hFFFF_FFFF)};
      6:  v = '{3'd4, 32'h8000_0000, 32'd0,       1'b1, e(0, 1, 0, 32'h8000_0000)};
      7:  v = '{3'd4, 32'd0,        32'hFFFF_FFFF, 1'b0, e(1, 0, 1, 32'h0)};
      8:  v = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, e(0, 0, 0, 32'hF000_F000)};
      9:  v = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, e(0, 0, 0, 32'hFFF0_FFF0)};
      default: v = '{3'd6, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, e(1, 0, 0, 32'h0)};
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MIN_NEG;
      3:       return ~MIN_NEG;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DG = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    localparam int ND = WIDTH / DG;
    localparam int KR = (ND >= 2) ? 2 : 1;

    logic             rst_n, in_valid, in_ready, cin, out_valid, out_ready;
    logic             cout, overflow, zero;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, result;
    logic [1:0]       dbg_state;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    last_exp;
    bit               done = 1'b0;

    digit_serial_alu #(.WIDTH(WIDTH), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero),
      .dbg_state(dbg_state)
    );

    function automatic string nm(input string s);
      return $sformatf("d%0d %s", DG, s);
    endfunction

    // Every cycle with out_valid: outputs must equal the oldest expected result.
    initial begin
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) check(nm("unexpected out_valid"), 64'(out_valid), 64'd0);
          else begin
            check(nm("result bundle"), 64'({zero, overflow, cout, result}), 64'(exp_q[0]));
            if (out_ready === 1'b1) void'(exp_q.pop_front());
          end
        end
      end
    end

    task automatic accept(input logic [2:0] o, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic ci, input bit push);
      int n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op       = o;
      a        = av;
      b        = bv;
      cin      = ci;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check(nm("accept in_ready"), 64'(in_ready), 64'd1);
      if (push) begin
        last_exp = model(o, av, bv, ci);
        exp_q.push_back(last_exp);
      end
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      op       = 3'($urandom_range(0, 7));
      a        = $urandom;
      b        = $urandom;
      cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic latency();
      int lat = -1;
      bit busy_ok = 1'b1;
      for (int k = 0; k <= ND + 4; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          lat = k;
          break;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
      end
      check(nm("latency"), 64'(lat), 64'(ND));
      check(nm("busy in_ready low"), 64'(busy_ok), 64'd1);
    endtask

    task automatic collect(input int hold);
      bit st_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        in_valid = ~in_valid;
        a        = $urandom;
        b        = $urandom;
        op       = 3'($urandom_range(0, 7));
        @(negedge clk);
        if (in_ready !== 1'b0 || out_valid !== 1'b1) st_ok = 1'b0;
      end
      if (hold > 0) check(nm("hold state"), 64'(st_ok), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check(nm("post-handshake in_ready"), 64'(in_ready), 64'd1);
      check(nm("post-handshake out_valid"), 64'(out_valid), 64'd0);
      check(nm("post-handshake hold"), 64'({zero, overflow, cout, result}), 64'(last_exp));
    endtask

    initial begin
      vec_t v;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      last_exp  = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check(nm("reset in_ready"), 64'(in_ready), 64'd1);
      check(nm("reset out_valid"), 64'(out_valid), 64'd0);
      check(nm("reset outputs"), 64'({zero, overflow, cout, result}), 64'd0);

      for (int i = 0; i < NV; i++) begin
        v = vec(i);
        accept(v.op, v.a, v.b, v.ci, 1'b1);
        latency();
        collect((i == 0) ? 5 : $urandom_range(0, 2));
      end

      // Abort an in-flight ADD with a one-edge reset; nothing may come out of it.
      accept(3'd0, '1, 32'd1, 1'b0, 1'b0);
      repeat (KR - 1) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check(nm("abort in_ready"), 64'(in_ready), 64'd1);
      check(nm("abort out_valid"), 64'(out_valid), 64'd0);
      check(nm("abort outputs"), 64'({zero, overflow, cout, result}), 64'd0);
      accept(3'd0, 32'd3, 32'd4, 1'b0, 1'b1);
      latency();
      collect(1);

      for (int i = 0; i < 25; i++) begin
        accept(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), 1'b1);
        latency();
        collect($urandom_range(0, 3));
      end
      check(nm("queue drained"), 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    vec_t v;
    bit   all_done;
    // Hand-computed expectations pin the reference model itself.
    for (int i = 0; i < NV; i++) begin
      v = vec(i);
      check($sformatf("model pin %0d", i), 64'(model(v.op, v.a, v.b, v.ci)), 64'(v.exp_v));
    end
    all_done = 1'b0;
    for (int c = 0; c < 20000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done;
    end
    check("run completes in cycle budget", 64'(all_done), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
